// File: rtl/fir_tf_param.sv
// Parametrised transposed-form FIR filter with a double-buffered coefficient bank.
// Each valid sample is multiplied by every active coefficient at once. The products
// fold into a chain of partial-sum registers, so y[n] = sum_k h[k]*x[n-k] appears
// one clock after x[n]. Coefficients are written into a shadow bank and become
// active together on a commit. After reset every coefficient is 1, so the default
// behaviour is a TAPS-point moving sum.
module fir_tf_param #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS),
  parameter int ADDR_W = $clog2(TAPS)
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic signed [DATA_W-1:0] Xin,
  input  logic                     Xin_valid,
  input  logic                     Flush,
  input  logic                     Coef_we,
  input  logic        [ADDR_W-1:0] Coef_addr,
  input  logic signed [COEF_W-1:0] Coef_data,
  input  logic                     Coef_commit,
  output logic signed [ACC_W-1:0]  Yout,
  output logic                     Yout_valid
);

  localparam int PROD_W = DATA_W + COEF_W;

  // Addresses are compared one bit wider, so the tap count itself is representable
  // even when TAPS is a power of two.
  localparam logic [ADDR_W:0] TAPS_LIM = (ADDR_W + 1)'(TAPS);

  logic signed [COEF_W-1:0] coef_shd [TAPS];
  logic signed [COEF_W-1:0] coef_act [TAPS];

  // Partial sums in transposed order: r[1] feeds the output adder, r[TAPS-1] is the tail.
  logic signed [ACC_W-1:0]  r        [1:TAPS-1];

  logic signed [PROD_W-1:0] prod_full [TAPS];
  logic signed [ACC_W-1:0]  prod      [TAPS];
  logic                     addr_ok;

  // Writes to addresses beyond the last tap are dropped. This only matters when
  // TAPS is not a power of two.
  assign addr_ok = ({1'b0, Coef_addr} < TAPS_LIM);

  // Multiply the current sample by every active coefficient at full precision.
  // The products are then sign-extended to the accumulator width.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod_full[k] = PROD_W'(coef_act[k]) * PROD_W'(Xin);
      prod[k]      = ACC_W'(prod_full[k]);
    end
  end

  // Coefficient banks.
  // A commit copies the shadow bank as it stood before this edge.
  // A write in the same cycle therefore lands in the shadow bank only.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        coef_shd[k] <= COEF_W'(1);
        coef_act[k] <= COEF_W'(1);
      end
    end else begin
      if (Coef_commit) begin
        coef_act <= coef_shd;
      end
      if (Coef_we && addr_ok) begin
        coef_shd[Coef_addr] <= Coef_data;
      end
    end
  end

  // Filter datapath.
  // Flush clears the partial sums and drops any coincident sample; Yout keeps its value.
  // Idle cycles hold every register, so gaps between samples do not disturb the sequence.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Yout       <= '0;
      Yout_valid <= 1'b0;
      for (int k = 1; k < TAPS; k++) begin
        r[k] <= '0;
      end
    end else if (Flush) begin
      Yout_valid <= 1'b0;
      for (int k = 1; k < TAPS; k++) begin
        r[k] <= '0;
      end
    end else if (Xin_valid) begin
      Yout       <= prod[0] + r[1];
      Yout_valid <= 1'b1;
      for (int k = 1; k < TAPS - 1; k++) begin
        r[k] <= prod[k] + r[k+1];
      end
      r[TAPS-1] <= prod[TAPS-1];
    end else begin
      Yout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_tf_param.sv
// Testbench for fir_tf_param.
// Two instances (8 taps and 5 taps) receive identical stimulus.
// A reference model keeps the recent samples and the coefficient bank that was
// active when each sample arrived. The expected output is a plain weighted sum
// over that window. Stimulus pushes expectations into per-instance queues, and a
// negedge monitor pops and compares them whenever an instance raises Yout_valid.
module tb_fir_tf_param;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int ACC_W  = 35;
  localparam int ADDR_W = 3;

  logic                     Clk = 1'b0;
  logic                     Rst_n;
  logic signed [DATA_W-1:0] Xin;
  logic                     Xin_valid;
  logic                     Flush;
  logic                     Coef_we;
  logic        [ADDR_W-1:0] Coef_addr;
  logic signed [COEF_W-1:0] Coef_data;
  logic                     Coef_commit;
  logic signed [ACC_W-1:0]  yA, yB;
  logic                     vA, vB;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  // Reference model state, indexed [instance].
  longint shadowM [2][8];
  longint activeM [2][8];
  longint histX   [2][8];
  longint histH   [2][8][8];
  int     histN   [2];
  longint lastY   [2];
  longint expA [$];
  longint expB [$];

  always #5 Clk = ~Clk;

  fir_tf_param #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(8)) dutA (
    .Clk(Clk), .Rst_n(Rst_n), .Xin(Xin), .Xin_valid(Xin_valid), .Flush(Flush),
    .Coef_we(Coef_we), .Coef_addr(Coef_addr), .Coef_data(Coef_data),
    .Coef_commit(Coef_commit), .Yout(yA), .Yout_valid(vA)
  );

  fir_tf_param #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(5)) dutB (
    .Clk(Clk), .Rst_n(Rst_n), .Xin(Xin), .Xin_valid(Xin_valid), .Flush(Flush),
    .Coef_we(Coef_we), .Coef_addr(Coef_addr), .Coef_data(Coef_data),
    .Coef_commit(Coef_commit), .Yout(yB), .Yout_valid(vB)
  );

  function automatic int tapsOf(input int d);
    return (d == 0) ? 8 : 5;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model the effect of the coming clock edge on instance d, using the inputs now driven.
  task automatic modelEdge(input int d);
    longint y;
    if (Flush) begin
      histN[d] = 0;
    end else if (Xin_valid) begin
      for (int j = 7; j > 0; j--) begin
        histX[d][j] = histX[d][j-1];
        for (int k = 0; k < 8; k++) histH[d][j][k] = histH[d][j-1][k];
      end
      histX[d][0] = longint'(Xin);
      for (int k = 0; k < 8; k++) histH[d][0][k] = activeM[d][k];
      if (histN[d] < tapsOf(d)) histN[d]++;
      y = 0;
      for (int j = 0; j < histN[d]; j++) y += histH[d][j][j] * histX[d][j];
      if (d == 0) expA.push_back(y);
      else        expB.push_back(y);
    end
    if (Coef_commit) begin
      for (int k = 0; k < 8; k++) activeM[d][k] = shadowM[d][k];
    end
    if (Coef_we && (int'(Coef_addr) < tapsOf(d))) begin
      shadowM[d][Coef_addr] = longint'(Coef_data);
    end
  endtask

  task automatic applyStimulus(input logic signed [15:0] x, input logic xv, input logic fl,
                               input logic we, input logic [2:0] addr,
                               input logic signed [15:0] data, input logic commit);
    Rst_n       = 1'b1;
    Xin         = x;
    Xin_valid   = xv;
    Flush       = fl;
    Coef_we     = we;
    Coef_addr   = addr;
    Coef_data   = data;
    Coef_commit = commit;
    modelEdge(0);
    modelEdge(1);
    @(posedge Clk);
    #1;
  endtask

  // Reset is held for one edge while every other input is randomised.
  // This shows that reset overrides all of them.
  task automatic doReset();
    Rst_n       = 1'b0;
    Xin         = 16'($urandom);
    Xin_valid   = 1'b1;
    Flush       = 1'($urandom);
    Coef_we     = 1'b1;
    Coef_addr   = 3'($urandom);
    Coef_data   = 16'($urandom);
    Coef_commit = 1'b1;
    @(posedge Clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) begin
        shadowM[d][k] = 1;
        activeM[d][k] = 1;
      end
      histN[d] = 0;
      lastY[d] = 0;
    end
    checkOutput("reset_yA", longint'(yA), 0);
    checkOutput("reset_vA", longint'(vA), 0);
    checkOutput("reset_yB", longint'(yB), 0);
    checkOutput("reset_vB", longint'(vB), 0);
  endtask

  // Load all eight shadow entries, then commit and flush for a clean switch.
  task automatic loadBank(input int h [8]);
    for (int k = 0; k < 8; k++) applyStimulus(16'sd0, 1'b0, 1'b0, 1'b1, 3'(k), 16'(h[k]), 1'b0);
    applyStimulus(16'sd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'sd0, 1'b1);
    applyStimulus(16'sd0, 1'b0, 1'b1, 1'b0, 3'd0, 16'sd0, 1'b0);
  endtask

  task automatic sample(input logic signed [15:0] x);
    applyStimulus(x, 1'b1, 1'b0, 1'b0, 3'd0, 16'sd0, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(16'sd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'sd0, 1'b0);
  endtask

  task automatic monitorOne(input int d, input longint y, input logic v);
    longint e;
    if (v) begin
      if ((d == 0 && expA.size() == 0) || (d == 1 && expB.size() == 0)) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid dut=%0d actual=1 expected=0 at %0t", d, $time);
      end else begin
        e = (d == 0) ? expA.pop_front() : expB.pop_front();
        checkOutput(d == 0 ? "yout_A" : "yout_B", y, e);
        lastY[d] = e;
      end
    end else begin
      checkOutput(d == 0 ? "hold_A" : "hold_B", y, lastY[d]);
    end
  endtask

  // Monitor: sample both instances on the falling edge, away from the active edge.
  always @(negedge Clk) begin
    if (started) begin
      monitorOne(0, longint'(yA), vA);
      monitorOne(1, longint'(yB), vB);
    end
  end

  initial begin
    int h [8];
    doReset();
    started = 1'b1;

    // Default moving sum: constant input ramps up to the tap count, then stays there.
    repeat (12) sample(16'sd1);

    // Identity bank, impulse of 100.
    h = '{1, 0, 0, 0, 0, 0, 0, 0};
    loadBank(h);
    sample(16'sd100);
    repeat (6) sample(16'sd0);

    // h = 1,2,3,4 with an impulse of 5: once back-to-back, once with idle gaps.
    h = '{1, 2, 3, 4, 0, 0, 0, 0};
    loadBank(h);
    sample(16'sd5);
    repeat (5) sample(16'sd0);
    applyStimulus(16'sd0, 1'b0, 1'b1, 1'b0, 3'd0, 16'sd0, 1'b0);
    sample(16'sd5);
    for (int i = 0; i < 5; i++) begin
      repeat (3) idle();
      sample(16'sd0);
    end

    // A commit coinciding with a sample, plus a write to address 2 in the same cycle.
    for (int k = 0; k < 8; k++) applyStimulus(16'sd0, 1'b0, 1'b0, 1'b1, 3'(k), 16'sd7, 1'b0);
    applyStimulus(16'sd10, 1'b1, 1'b0, 1'b1, 3'd2, -16'sd9, 1'b1);
    repeat (4) sample(16'sd3);
    applyStimulus(16'sd1, 1'b1, 1'b0, 1'b0, 3'd0, 16'sd0, 1'b1);
    repeat (4) sample(16'sd2);

    // Worst-case magnitude: every product is +2^30 and the full sum must not wrap.
    h = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    loadBank(h);
    repeat (12) sample(-16'sd32768);
    checkOutput("worst_case_A", longint'(yA), 64'sd8589934592);
    checkOutput("worst_case_B", longint'(yB), 64'sd5368709120);

    // Reset mid-stream, then Flush coinciding with a sample.
    repeat (3) sample(16'sd1234);
    doReset();
    repeat (3) sample(16'sd2);
    applyStimulus(16'sd50, 1'b1, 1'b1, 1'b0, 3'd0, 16'sd0, 1'b0);
    checkOutput("flush_drop_vA", longint'(vA), 0);
    checkOutput("flush_drop_vB", longint'(vB), 0);
    repeat (3) sample(16'sd4);

    // Randomised traffic: samples, gaps, flushes, shadow writes (including addresses past
    // the 5-tap instance's range) and commits in arbitrary combination.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(16'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 9) < 3), 3'($urandom), 16'($urandom),
                    ($urandom_range(0, 19) == 0));
    end

    repeat (3) idle();
    checkOutput("drained_A", longint'(expA.size()), 0);
    checkOutput("drained_B", longint'(expB.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
